// File: rtl/ad9226_capture_ctrl_if.sv
// Control, ADC sample and buffer-write signals of the AD9226 capture controller.
// The controller drives through the master modport; the host/ADC side uses slave.
interface ad9226_capture_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic [11:0]       adc_data;
    logic              adc_data_otr;
    logic              start;
    logic              abort;
    logic              trig_mode;
    logic [11:0]       trig_level;
    logic [7:0]        decim;
    logic [ADDR_W-1:0] sample_count;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [12:0]       wr_data;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              otr_seen;

    modport master (
        input  adc_data, adc_data_otr, start, abort, trig_mode, trig_level, decim, sample_count,
        output wr_en, wr_addr, wr_data, busy, done, aborted, otr_seen
    );

    modport slave (
        output adc_data, adc_data_otr, start, abort, trig_mode, trig_level, decim, sample_count,
        input  wr_en, wr_addr, wr_data, busy, done, aborted, otr_seen
    );
endinterface

// File: rtl/ad9226_capture_ctrl.sv
// AD9226 capture sequencer: optional rising-threshold trigger, decimation and
// buffer write of {otr, data}; samples are accepted every second master_clock cycle.
module ad9226_capture_ctrl #(
    parameter int ADDR_W = 16
) (
    input  logic                  master_clock,
    input  logic                  reset,
    ad9226_capture_ctrl_if.master bus
);

    // state     | meaning
    // IDLE      | waiting for start
    // WAIT_TRIG | watching for a rising crossing of the latched level
    // CAPTURE   | writing every (decim+1)th accepted sample
    // DONE      | one-cycle done pulse
    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

    state_t            state;
    logic              phase;
    logic [11:0]       level_q;
    logic [11:0]       prev_q;
    logic [7:0]        decim_q;
    logic [7:0]        dec_cnt;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] next_addr;

    logic              trig_hit;
    logic              do_write;
    logic              last_write;
    logic [7:0]        dec_next;

    always_comb begin
        trig_hit   = (prev_q < level_q) && (bus.adc_data >= level_q);
        do_write   = phase && (((state == CAPTURE) && (dec_cnt == 8'd0)) ||
                               ((state == WAIT_TRIG) && trig_hit));
        last_write = (next_addr + ADDR_W'(1)) == count_q;
        dec_next   = (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
    end

    always_ff @(posedge master_clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            phase        <= 1'b0;
            level_q      <= '0;
            prev_q       <= '0;
            decim_q      <= '0;
            dec_cnt      <= '0;
            count_q      <= '0;
            next_addr    <= '0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.aborted  <= 1'b0;
            bus.otr_seen <= 1'b0;
        end else begin
            phase       <= ~phase;
            bus.wr_en   <= 1'b0;
            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;

            case (state)
                IDLE: begin
                    // a simultaneous abort cancels the arm request
                    if (bus.start && !bus.abort) begin
                        if (bus.sample_count == '0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            level_q      <= bus.trig_level;
                            decim_q      <= bus.decim;
                            count_q      <= bus.sample_count;
                            dec_cnt      <= '0;
                            next_addr    <= '0;
                            bus.wr_addr  <= '0;
                            prev_q       <= 12'hFFF;
                            bus.otr_seen <= 1'b0;
                            bus.busy     <= 1'b1;
                            state        <= bus.trig_mode ? WAIT_TRIG : CAPTURE;
                        end
                    end
                end

                WAIT_TRIG, CAPTURE: begin
                    if (bus.abort) begin
                        state       <= IDLE;
                        bus.busy    <= 1'b0;
                        bus.aborted <= 1'b1;
                    end else if (phase) begin
                        if (state == WAIT_TRIG) begin
                            prev_q <= bus.adc_data;
                        end
                        // the triggering sample counts as the first capture sample
                        if (do_write) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= next_addr;
                            bus.wr_data <= {bus.adc_data_otr, bus.adc_data};
                            next_addr   <= next_addr + ADDR_W'(1);
                            dec_cnt     <= dec_next;
                            if (bus.adc_data_otr) begin
                                bus.otr_seen <= 1'b1;
                            end
                            if (last_write) begin
                                state    <= DONE;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                            end else begin
                                state <= CAPTURE;
                            end
                        end else if (state == CAPTURE) begin
                            dec_cnt <= dec_next;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ad9226_capture_ctrl.md
AD9226_CAPTURE_CTRL -- requirements
Module: ad9226_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning the width of the sample-buffer address and of the sample count.
REQ-002 SHALL have port master_clock  in  1  sole clock; all logic samples on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port adc_data  in  12  registered sample from the ADC driver, unsigned offset binary.
REQ-005 SHALL have port adc_data_otr  in  1  out-of-range flag accompanying adc_data.
REQ-006 SHALL have port start  in  1  one-cycle arm request.
REQ-007 SHALL have port abort  in  1  one-cycle cancel request.
REQ-008 SHALL have port trig_mode  in  1  0 = immediate capture, 1 = rising-threshold trigger.
REQ-009 SHALL have port trig_level  in  12  threshold used for the trigger compare.
REQ-010 SHALL have port decim  in  8  decimation; write 1 of every decim+1 accepted samples.
REQ-011 SHALL have port sample_count  in  ADDR_W  number of samples to write per capture.
REQ-012 SHALL have port wr_en  out  1  buffer write strobe.
REQ-013 SHALL have port wr_addr  out  ADDR_W  buffer write address.
REQ-014 SHALL have port wr_data  out  13  buffer write data, {otr, data[11:0]}.
REQ-015 SHALL have port busy  out  1  high in WAIT_TRIG and CAPTURE.
REQ-016 SHALL have port done  out  1  one-cycle pulse when a capture completes.
REQ-017 SHALL have port aborted  out  1  one-cycle pulse when an abort is taken.
REQ-018 SHALL have port otr_seen  out  1  sticky flag: an OTR sample was written during the current or last capture.

Function
REQ-019 SHALL keep an internal phase bit that toggles every cycle; a sample is "accepted" only when phase = 1, which gives one sample per two master_clock cycles, matching the ADC clock rate.
REQ-020 SHALL implement states IDLE, WAIT_TRIG, CAPTURE and DONE.
REQ-021 IDLE: start=1 with sample_count!=0 SHALL latch trig_mode, trig_level, decim and sample_count, clear otr_seen, and go to CAPTURE if trig_mode=0, otherwise to WAIT_TRIG.
REQ-022 IDLE: start=1 with sample_count=0 SHALL go to DONE without any write.
REQ-023 WAIT_TRIG SHALL go to CAPTURE on the accepted sample where the previous accepted sample < trig_level and the current accepted sample >= trig_level; the triggering sample SHALL be the first sample written.
REQ-024 The previous-sample register SHALL be reset to 0xFFF on entry to WAIT_TRIG, so the first accepted sample can never trigger.
REQ-025 CAPTURE SHALL hold a decimation counter that is cleared on entry, so the first accepted sample is written; thereafter it SHALL write every (decim+1)th accepted sample.
REQ-026 A write SHALL assert wr_en for one cycle, with wr_data = {adc_data_otr, adc_data} of the accepted sample, one cycle after acceptance (registered outputs).
REQ-027 wr_addr SHALL start at 0 for each capture and increment by 1 after each write; it never wraps, because the capture ends at sample_count.
REQ-028 A written sample with otr=1 SHALL set otr_seen, which stays set until the next accepted start or reset.
REQ-029 The write that brings the written count to the latched sample_count SHALL be the last; the state SHALL then go to DONE.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-031 abort=1 in WAIT_TRIG or CAPTURE SHALL go to IDLE on the next edge, suppress any pending write, pulse aborted, and produce no done.
REQ-032 abort in IDLE or DONE SHALL be ignored.
REQ-033 If start and abort are high together, abort SHALL win.
REQ-034 start while busy=1 SHALL be ignored.
REQ-035 Configuration inputs SHALL be ignored except at start.

Reset
REQ-036 reset=1 SHALL immediately force: state IDLE, phase 0, wr_en 0, wr_addr 0, wr_data 0, busy 0, done 0, aborted 0, otr_seen 0, counters 0.
REQ-037 Reset asserted mid-capture SHALL discard the capture with no done pulse.

Verification
REQ-038 Immediate capture: trig_mode=0, decim=0, sample_count=4, ramp 0,1,2,... -> 4 writes at addr 0..3 with consecutive ramp values, then one done pulse, then busy=0.
REQ-039 Threshold trigger: trig_mode=1, trig_level=0x800, samples 0x700, 0x7FF, 0x800, 0x900, sample_count=2 -> first write is 0x800 at addr 0, second is 0x900 at addr 1.
REQ-040 Decimation: decim=2, sample_count=3, accepted ramp 10..20 -> writes 10, 13, 16 at addr 0..2.
REQ-041 OTR: trig_mode=0, sample_count=3, middle sample otr=1 -> wr_data[12]=1 on addr 1 and otr_seen=1 after done; the next start clears it.
REQ-042 Abort: abort in CAPTURE after 2 of 8 writes -> aborted pulse, no done, no further wr_en, IDLE.
REQ-043 Edge cases: (a) start with sample_count=0 -> done next cycle with no write; (b) start and abort together while busy -> abort taken; (c) async reset mid-capture -> all outputs 0 immediately.
